// File: rtl/trap_sequencer.sv
// Machine-mode trap sequencer: stalls, writes mepc/mcause/mstatus through one CSR port, then redirects.
// Optional `TRAP_VECTORED_EN adds vectored interrupt dispatch when mtvec[1:0] == 2'b01.
module trap_sequencer #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset_n,
   input  logic            instr_valid,
   input  logic [XLEN-1:0] instr_pc,
   input  logic            ecall_type,
   input  logic            mret_type,
   input  logic            irq_ext,
   input  logic            irq_timer,
   input  logic [XLEN-1:0] mstatus,
   input  logic [XLEN-1:0] mtvec,
   input  logic [XLEN-1:0] mepc,
   output logic            pipe_stall,
   output logic            pipe_flush,
   output logic            redirect_valid,
   output logic [XLEN-1:0] redirect_pc,
   output logic            csr_we,
   output logic [11:0]     csr_addr,
   output logic [XLEN-1:0] csr_wdata
);

   localparam logic [2:0] IDLE       = 3'd0;
   localparam logic [2:0] WR_MEPC    = 3'd1;
   localparam logic [2:0] WR_MCAUSE  = 3'd2;
   localparam logic [2:0] WR_MSTATUS = 3'd3;
   localparam logic [2:0] REDIRECT   = 3'd4;

   localparam logic [11:0] ADDR_MSTATUS = 12'h300;
   localparam logic [11:0] ADDR_MEPC    = 12'h341;
   localparam logic [11:0] ADDR_MCAUSE  = 12'h342;

   localparam logic [XLEN-1:0] CAUSE_IRQ_EXT   = {1'b1, {(XLEN-6){1'b0}}, 5'd11};
   localparam logic [XLEN-1:0] CAUSE_IRQ_TIMER = {1'b1, {(XLEN-6){1'b0}}, 5'd7};
   localparam logic [XLEN-1:0] CAUSE_ECALL     = {{(XLEN-5){1'b0}}, 5'd11};

   logic [2:0]      state_q, state_d;
   logic [XLEN-1:0] pc_q, pc_d;
   logic [XLEN-1:0] cause_q, cause_d;
   logic [XLEN-1:0] mstatus_q, mstatus_d;
   logic [XLEN-1:0] mtvec_q, mtvec_d;
   logic [XLEN-1:0] mepc_q, mepc_d;
   logic            is_mret_q, is_mret_d;

   logic            csr_we_q, csr_we_d;
   logic [11:0]     csr_addr_q, csr_addr_d;
   logic [XLEN-1:0] csr_wdata_q, csr_wdata_d;
   logic            redirect_valid_q, redirect_valid_d;
   logic [XLEN-1:0] redirect_pc_q, redirect_pc_d;
   logic            pipe_flush_q, pipe_flush_d;

   logic            take_ext;
   logic            take_timer;
   logic            accept;
   logic            trig_mret;
   logic [XLEN-1:0] trig_cause;
   logic [XLEN-1:0] trap_base;
   logic [XLEN-1:0] trap_target;
   logic [XLEN-1:0] mstatus_trap;
   logic [XLEN-1:0] mstatus_mret;

   // Trigger detection and priority: external > timer > ecall > mret.
   always_comb begin
      take_ext   = irq_ext & mstatus[3];
      take_timer = irq_timer & mstatus[3];
      accept     = (state_q == IDLE) & instr_valid &
                   (take_ext | take_timer | ecall_type | mret_type);
      trig_mret  = 1'b0;
      trig_cause = '0;
      if (take_ext) begin
         trig_cause = CAUSE_IRQ_EXT;
      end else if (take_timer) begin
         trig_cause = CAUSE_IRQ_TIMER;
      end else if (ecall_type) begin
         trig_cause = CAUSE_ECALL;
      end else if (mret_type) begin
         trig_mret = 1'b1;
      end
   end

   // Next-state and operand latching; operands only change on acceptance.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      cause_d   = cause_q;
      mstatus_d = mstatus_q;
      mtvec_d   = mtvec_q;
      mepc_d    = mepc_q;
      is_mret_d = is_mret_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d   = trig_mret ? WR_MSTATUS : WR_MEPC;
               pc_d      = instr_pc;
               cause_d   = trig_cause;
               mstatus_d = mstatus;
               mtvec_d   = mtvec;
               mepc_d    = mepc;
               is_mret_d = trig_mret;
            end
         end
         WR_MEPC:    state_d = WR_MCAUSE;
         WR_MCAUSE:  state_d = WR_MSTATUS;
         WR_MSTATUS: state_d = REDIRECT;
         REDIRECT:   state_d = IDLE;
         default:    state_d = IDLE;
      endcase
   end

   // Derived write data and trap target, from the values the next state will hold.
   always_comb begin
      mstatus_trap    = mstatus_d;
      mstatus_trap[7] = mstatus_d[3];
      mstatus_trap[3] = 1'b0;
      mstatus_mret    = mstatus_d;
      mstatus_mret[3] = mstatus_d[7];
      mstatus_mret[7] = 1'b1;
      trap_base       = {mtvec_d[XLEN-1:2], 2'b00};
      trap_target     = trap_base;
`ifdef TRAP_VECTORED_EN
      // Interrupt causes have the top bit set; exceptions always use the base.
      if (cause_d[XLEN-1] && (mtvec_d[1:0] == 2'b01)) begin
         trap_target = trap_base + {{(XLEN-7){1'b0}}, cause_d[4:0], 2'b00};
      end
`endif
   end

`ifndef TRAP_VECTORED_EN
   logic unused_mode;
   assign unused_mode = ^mtvec_q[1:0];
`endif

   logic unused_pc_lo;
   assign unused_pc_lo = ^pc_q[1:0];

   // Registered outputs are decoded from the state being entered.
   always_comb begin
      csr_we_d         = 1'b0;
      csr_addr_d       = '0;
      csr_wdata_d      = '0;
      redirect_valid_d = 1'b0;
      redirect_pc_d    = '0;
      pipe_flush_d     = 1'b0;
      case (state_d)
         WR_MEPC: begin
            csr_we_d    = 1'b1;
            csr_addr_d  = ADDR_MEPC;
            csr_wdata_d = {pc_d[XLEN-1:2], 2'b00};
         end
         WR_MCAUSE: begin
            csr_we_d    = 1'b1;
            csr_addr_d  = ADDR_MCAUSE;
            csr_wdata_d = cause_d;
         end
         WR_MSTATUS: begin
            csr_we_d    = 1'b1;
            csr_addr_d  = ADDR_MSTATUS;
            csr_wdata_d = is_mret_d ? mstatus_mret : mstatus_trap;
         end
         REDIRECT: begin
            redirect_valid_d = 1'b1;
            pipe_flush_d     = 1'b1;
            redirect_pc_d    = is_mret_d ? mepc_d : trap_target;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q          <= IDLE;
         pc_q             <= '0;
         cause_q          <= '0;
         mstatus_q        <= '0;
         mtvec_q          <= '0;
         mepc_q           <= '0;
         is_mret_q        <= 1'b0;
         csr_we_q         <= 1'b0;
         csr_addr_q       <= '0;
         csr_wdata_q      <= '0;
         redirect_valid_q <= 1'b0;
         redirect_pc_q    <= '0;
         pipe_flush_q     <= 1'b0;
      end else begin
         state_q          <= state_d;
         pc_q             <= pc_d;
         cause_q          <= cause_d;
         mstatus_q        <= mstatus_d;
         mtvec_q          <= mtvec_d;
         mepc_q           <= mepc_d;
         is_mret_q        <= is_mret_d;
         csr_we_q         <= csr_we_d;
         csr_addr_q       <= csr_addr_d;
         csr_wdata_q      <= csr_wdata_d;
         redirect_valid_q <= redirect_valid_d;
         redirect_pc_q    <= redirect_pc_d;
         pipe_flush_q     <= pipe_flush_d;
      end
   end

   // Stall is raised combinationally in the accept cycle, then held by the state.
   assign pipe_stall     = (accept & reset_n) | (state_q != IDLE);
   assign csr_we         = csr_we_q;
   assign csr_addr       = csr_addr_q;
   assign csr_wdata      = csr_wdata_q;
   assign redirect_valid = redirect_valid_q;
   assign redirect_pc    = redirect_pc_q;
   assign pipe_flush     = pipe_flush_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Bench for trap_sequencer: directed scenarios plus random transactions against a per-cycle
// expected-output trace derived from the trap/mret rules.
module tb_trap_sequencer;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        instr_valid;
   logic [31:0] instr_pc;
   logic        ecall_type;
   logic        mret_type;
   logic        irq_ext;
   logic        irq_timer;
   logic [31:0] mstatus;
   logic [31:0] mtvec;
   logic [31:0] mepc;
   logic        pipe_stall;
   logic        pipe_flush;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        csr_we;
   logic [11:0] csr_addr;
   logic [31:0] csr_wdata;

   always #5 clk = ~clk;

   trap_sequencer #(.XLEN(32)) dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .instr_valid    (instr_valid),
      .instr_pc       (instr_pc),
      .ecall_type     (ecall_type),
      .mret_type      (mret_type),
      .irq_ext        (irq_ext),
      .irq_timer      (irq_timer),
      .mstatus        (mstatus),
      .mtvec          (mtvec),
      .mepc           (mepc),
      .pipe_stall     (pipe_stall),
      .pipe_flush     (pipe_flush),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .csr_we         (csr_we),
      .csr_addr       (csr_addr),
      .csr_wdata      (csr_wdata)
   );

   typedef struct packed {
      logic        stall;
      logic        we;
      logic [11:0] addr;
      logic [31:0] wdata;
      logic        rv;
      logic        flush;
      logic [31:0] rpc;
   } obs_t;

   obs_t obs;
   assign obs = {pipe_stall, csr_we, csr_addr, csr_wdata, redirect_valid, pipe_flush, redirect_pc};

   int   n_assert = 0;
   int   n_fail   = 0;
   obs_t exp_q[$];

   task automatic chk(input string tag, input obs_t exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic obs_t rec(input logic stall);
      obs_t r;
      r       = '0;
      r.stall = stall;
      return r;
   endfunction

   function automatic obs_t wr(input logic [11:0] a, input logic [31:0] d);
      obs_t r;
      r       = rec(1'b1);
      r.we    = 1'b1;
      r.addr  = a;
      r.wdata = d;
      return r;
   endfunction

   function automatic obs_t redir(input logic [31:0] pc);
      obs_t r;
      r       = rec(1'b1);
      r.rv    = 1'b1;
      r.flush = 1'b1;
      r.rpc   = pc;
      return r;
   endfunction

   // Expected trace, one entry per cycle starting at the trigger cycle.
   task automatic build_expect(input logic v, input logic ec, input logic mr, input logic ie,
                               input logic it, input logic [31:0] pc, input logic [31:0] ms,
                               input logic [31:0] tv, input logic [31:0] ep);
      logic [31:0] cause;
      logic [31:0] target;
      logic        mie;
      mie = ms[3];
      exp_q.delete();
      if (!v || !((ie && mie) || (it && mie) || ec || mr)) begin
         exp_q.push_back(rec(1'b0));
      end else if ((ie && mie) || (it && mie) || ec) begin
         if (ie && mie)      cause = 32'h8000_000B;
         else if (it && mie) cause = 32'h8000_0007;
         else                cause = 32'h0000_000B;
         target = tv & ~32'h3;
`ifdef TRAP_VECTORED_EN
         if (cause >= 32'h8000_0000 && tv % 4 == 1) target = target + 4 * (cause % 32);
`endif
         exp_q.push_back(rec(1'b1));
         exp_q.push_back(wr(12'h341, pc & ~32'h3));
         exp_q.push_back(wr(12'h342, cause));
         exp_q.push_back(wr(12'h300, (ms & ~32'h88) | (mie ? 32'h80 : 32'h0)));
         exp_q.push_back(redir(target));
         exp_q.push_back(rec(1'b0));
      end else begin
         exp_q.push_back(rec(1'b1));
         exp_q.push_back(wr(12'h300, (ms & ~32'h8) | 32'h80 | (ms[7] ? 32'h8 : 32'h0)));
         exp_q.push_back(redir(ep));
         exp_q.push_back(rec(1'b0));
      end
   endtask

   task automatic scramble();
      instr_valid = 1'($urandom);
      instr_pc    = $urandom;
      ecall_type  = 1'($urandom);
      mret_type   = 1'($urandom);
      irq_ext     = 1'($urandom);
      irq_timer   = 1'($urandom);
      mstatus     = $urandom;
      mtvec       = $urandom;
      mepc        = $urandom;
   endtask

   task automatic txn(input string tag, input logic v, input logic ec, input logic mr,
                      input logic ie, input logic it, input logic [31:0] pc,
                      input logic [31:0] ms, input logic [31:0] tv, input logic [31:0] ep);
      int n;
      build_expect(v, ec, mr, ie, it, pc, ms, tv, ep);
      n = exp_q.size();
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            instr_valid = v;
            ecall_type  = ec;
            mret_type   = mr;
            irq_ext     = ie;
            irq_timer   = it;
            instr_pc    = pc;
            mstatus     = ms;
            mtvec       = tv;
            mepc        = ep;
         end else begin
            // Latched operands must not follow the live inputs mid-sequence.
            scramble();
            if (k == n - 1) instr_valid = 1'b0;
         end
         @(negedge clk);
         chk($sformatf("%s c%0d", tag, k), exp_q[k]);
      end
   endtask

   initial begin
      reset_n     = 1'b0;
      instr_valid = 1'b0;
      instr_pc    = '0;
      ecall_type  = 1'b0;
      mret_type   = 1'b0;
      irq_ext     = 1'b0;
      irq_timer   = 1'b0;
      mstatus     = '0;
      mtvec       = '0;
      mepc        = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset", rec(1'b0));
      reset_n = 1'b1;

      txn("ecall",      1, 1, 0, 0, 0, 32'h0000_0100, 32'h8,  32'h800, 32'h0);
      txn("mret",       1, 0, 1, 0, 0, 32'h0000_0200, 32'h80, 32'h800, 32'h104);
      txn("tmr_ecall",  1, 1, 0, 0, 1, 32'h0000_0300, 32'h8,  32'h800, 32'h0);
      txn("tmr_nomie",  1, 1, 0, 0, 1, 32'h0000_0304, 32'h0,  32'h800, 32'h0);
      txn("ecall_mret", 1, 1, 1, 0, 0, 32'h0000_0308, 32'h88, 32'h900, 32'h500);
      txn("ext_over_t", 1, 0, 0, 1, 1, 32'h0000_0312, 32'h8,  32'h800, 32'h0);
      for (int i = 0; i < 3; i++) txn("irq_inval", 0, 0, 0, 1, 0, 32'h400, 32'h8, 32'h800, 32'h0);
      txn("irq_valid",  1, 0, 0, 1, 0, 32'h0000_0400, 32'h8,  32'h800, 32'h0);
      txn("vec_ext",    1, 0, 0, 1, 0, 32'h0000_0404, 32'h8,  32'h801, 32'h0);
      txn("vec_ecall",  1, 1, 0, 0, 0, 32'h0000_0408, 32'h8,  32'h801, 32'h0);
      txn("vec_tmr",    1, 0, 0, 0, 1, 32'h0000_040C, 32'h8,  32'h803, 32'h0);

      // Reset asserted during the mcause write: nothing further may be written or redirected.
      build_expect(1, 1, 0, 0, 0, 32'h600, 32'h8, 32'h800, 32'h0);
      for (int k = 0; k < 5; k++) begin
         @(posedge clk);
         #1;
         if (k == 0) begin
            instr_valid = 1'b1;
            ecall_type  = 1'b1;
            mret_type   = 1'b0;
            irq_ext     = 1'b0;
            irq_timer   = 1'b0;
            instr_pc    = 32'h600;
            mstatus     = 32'h8;
            mtvec       = 32'h800;
         end else begin
            scramble();
            if (k >= 3) instr_valid = 1'b0;
         end
         reset_n = (k == 2) ? 1'b0 : 1'b1;
         @(negedge clk);
         chk($sformatf("rst_mid c%0d", k), (k < 3) ? exp_q[k] : rec(1'b0));
      end

      for (int i = 0; i < 60; i++) begin
         txn($sformatf("rand%0d", i), $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0,
             $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
             $urandom, $urandom, $urandom, $urandom);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle machine-mode trap controller between the decode stage's `mret_type`/`ecall_type` outputs and the CSR file's single write port. On an ecall or an enabled interrupt it stalls the pipeline, writes mepc, mcause and mstatus through the shared port in sequence, then flushes and redirects fetch to the trap vector. On mret it restores mstatus and redirects to mepc. Machine mode only; MPP is not modelled.

## Interface
Parameters:
- `XLEN`, 32, data/address width.

Ports:
- `clk`  in  1  core clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `instr_valid`  in  1  instruction in execute is valid and not flushed.
- `instr_pc`  in  XLEN  PC of that instruction.
- `ecall_type`  in  1  decoded ecall; qualified by `instr_valid`.
- `mret_type`  in  1  decoded mret; qualified by `instr_valid`.
- `irq_ext`  in  1  external interrupt pending and enabled in mie (level).
- `irq_timer`  in  1  timer interrupt pending and enabled in mie (level).
- `mstatus`  in  XLEN  current mstatus (MIE = bit 3, MPIE = bit 7).
- `mtvec`  in  XLEN  current mtvec.
- `mepc`  in  XLEN  current mepc.
- `pipe_stall`  out  1  freeze the pipeline.
- `pipe_flush`  out  1  kill all younger instructions.
- `redirect_valid`  out  1  load `redirect_pc` into the PC.
- `redirect_pc`  out  XLEN  fetch target.
- `csr_we`  out  1  CSR write-port enable.
- `csr_addr`  out  12  CSR write address.
- `csr_wdata`  out  XLEN  CSR write data.

## Operation
- States: IDLE, WR_MEPC, WR_MCAUSE, WR_MSTATUS, REDIRECT.
- Triggers are sampled only in IDLE with `instr_valid`=1, in this priority order:
  - `irq_ext & mstatus[3]`: cause 0x8000000B.
  - `irq_timer & mstatus[3]`: cause 0x80000007.
  - `ecall_type`: cause 0x0000000B.
  - `mret_type`.
- If `ecall_type` and `mret_type` are both high, ecall wins.
- On any trigger, latch `instr_pc`, the cause, `mstatus`, `mtvec` and `mepc`. Later changes to these inputs do not affect the sequence.
- Trap path: IDLE → WR_MEPC → WR_MCAUSE → WR_MSTATUS → REDIRECT → IDLE.
  - WR_MEPC: `csr_addr`=0x341, `csr_wdata`={pc[XLEN-1:2],2'b00}.
  - WR_MCAUSE: `csr_addr`=0x342, `csr_wdata`=cause.
  - WR_MSTATUS: `csr_addr`=0x300, `csr_wdata`=latched mstatus with bit7←bit3 and bit3←0.
  - REDIRECT: `redirect_pc`={mtvec[XLEN-1:2],2'b00}.
- mret path: IDLE → WR_MSTATUS → REDIRECT → IDLE.
  - WR_MSTATUS: `csr_wdata`=mstatus with bit3←bit7 and bit7←1.
  - REDIRECT: `redirect_pc`=latched mepc.
- The interrupted or ecall instruction does not retire; mepc points at it.
- Triggers are ignored outside IDLE.
- `instr_valid`=0 in IDLE: no trigger, even with an interrupt pending.
- Mid-sequence reset: return to IDLE immediately. No partial write or redirect is completed.

## Timing
- Reset values: all outputs 0, state IDLE.
- `pipe_stall` = trigger accepted (combinational, trigger cycle T) OR state≠IDLE. All other outputs are registered from state.
- Trap: T accept; T+1 mepc write; T+2 mcause write; T+3 mstatus write; T+4 `redirect_valid`=`pipe_flush`=1; T+5 IDLE, new trigger acceptable.
- mret: T accept; T+1 mstatus write; T+2 redirect+flush; T+3 IDLE.
- `csr_we` is high exactly one cycle per write state.
- `redirect_valid` and `pipe_flush` are high for exactly one cycle.
- `pipe_stall` stays high through the REDIRECT cycle.
- The CSR file commits writes at the clock edge ending the write cycle. The mstatus write is therefore visible at T+4 (trap) or T+2 (mret).

## Configuration
- `TRAP_VECTORED_EN` defined: for interrupts with latched mtvec[1:0]=2'b01, `redirect_pc`={mtvec[XLEN-1:2],2'b00} + (cause[4:0]<<2). Exceptions and mtvec[1:0]≠01 use the base address.
- `TRAP_VECTORED_EN` not defined: direct mode only. mtvec[1:0] is ignored and `redirect_pc`={mtvec[XLEN-1:2],2'b00} always.

## Test plan
- ecall: pc=0x0000_0100, mtvec=0x0000_0800, mstatus=0x8 → writes 0x341←0x100, 0x342←0xB, 0x300←0x80 on T+1..T+3. T+4: redirect to 0x800 with flush. `pipe_stall` high T..T+4.
- mret: mepc=0x104, mstatus=0x80 → T+1 0x300←0x88; T+2 redirect to 0x104; IDLE at T+3.
- Timer interrupt, MIE=1, plus ecall in the same cycle → cause 0x80000007 is written, mepc=`instr_pc`. Same with MIE=0 → ecall taken, cause 0xB.
- Interrupt with `instr_valid`=0 for 3 cycles → no stall or write; accepted in the first cycle `instr_valid`=1.
- `reset_n`=0 during WR_MCAUSE → the next cycle has all outputs 0 and state IDLE; no mstatus write and no redirect occur.
- With `TRAP_VECTORED_EN`, mtvec=0x801, external interrupt → redirect 0x82C. The same stimulus without the macro → redirect 0x800.
